// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  lsu_pkg : shared state type, funct3 codes and fault check for the LSU
//  Revision: 1.0
// ============================================================================
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        STORE_W = 3'd2,
        RMW_RD  = 3'd3,
        RMW_WR  = 3'd4,
        RESP    = 3'd5
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic misaligned;
        logic out_of_range;
    } fault_t;

    // Illegal funct3 encodings are reported as misaligned.
    function automatic fault_t fault_check(
        input logic        write,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input int unsigned mem_words
    );
        fault_t f;
        logic   illegal;
        if (write)
            illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        else
            illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        f.misaligned   = illegal
                       || ((funct3[1:0] == 2'b01) && addr[0])
                       || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        f.out_of_range = ({2'b00, addr[31:2]} >= mem_words);
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  lsu_lane_align : load byte/half extract + extend, sub-word store merge
//  Revision: 1.0
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    input  logic [31:0] data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [31:0] w_sel;

    assign w_sel = word >> {offset, 3'b000};

    always_comb begin
        load_data = 32'd0;
        case (funct3)
            F3_B:    load_data = {{24{w_sel[7]}}, w_sel[7:0]};
            F3_BU:   load_data = {24'd0, w_sel[7:0]};
            F3_H:    load_data = {{16{w_sel[15]}}, w_sel[15:0]};
            F3_HU:   load_data = {16'd0, w_sel[15:0]};
            F3_W:    load_data = word;
            default: load_data = 32'd0;
        endcase
    end

    // Lanes outside the stored byte/half pass through untouched.
    always_comb begin
        merge_data = word;
        if (funct3 == F3_B)
            merge_data[{offset, 3'b000} +: 8] = data[7:0];
        else if (funct3 == F3_H)
            merge_data[{offset[1], 4'b0000} +: 16] = data[15:0];
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  load_store_unit : one-at-a-time load/store controller for a word RAM
//  Revision: 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 128,
    parameter int unsigned RESET_STATE = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [2:0]  Req_Funct3,
    input  logic [31:0] Req_Address,
    input  logic [31:0] Req_Write_Data,
    output logic        Resp_Valid,
    input  logic        Resp_Ready,
    output logic [31:0] Resp_Read_Data,
    output logic        Resp_Misaligned,
    output logic        Resp_Out_Of_Range,
    output logic [31:0] Mem_Address,
    output logic [31:0] Mem_Write_Data,
    output logic        Mem_Write_Enable,
    input  logic [31:0] Mem_Read_Data
);

    localparam state_t C_RESET_STATE = state_t'(RESET_STATE[2:0]);

    state_t      r_state, w_next;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;
    logic        r_mis;
    logic        r_oor;

    fault_t      w_fault;
    logic        w_accept;
    logic [31:0] w_align_word;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    assign w_fault  = fault_check(Req_Write, Req_Funct3, Req_Address, MEM_WORDS);
    assign w_accept = Req_Valid && (r_state == IDLE);

    // One aligner serves both paths: live RAM data for loads, the captured word for merges.
    assign w_align_word = (r_state == RMW_WR) ? r_merge : Mem_Read_Data;

    lsu_lane_align u_align (
        .offset     (r_addr[1:0]),
        .funct3     (r_funct3),
        .word       (w_align_word),
        .data       (r_data),
        .load_data  (w_load_data),
        .merge_data (w_merge_data)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (Req_Valid) begin
                    if (w_fault.misaligned || w_fault.out_of_range)
                        w_next = RESP;
                    else if (!Req_Write)
                        w_next = LOAD;
                    else if (Req_Funct3 == F3_W)
                        w_next = STORE_W;
                    else
                        w_next = RMW_RD;
                end
            end
            LOAD:    w_next = RESP;
            STORE_W: w_next = RESP;
            RMW_RD:  w_next = RMW_WR;
            RMW_WR:  w_next = RESP;
            RESP:    if (Resp_Ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        Req_Ready        = (r_state == IDLE);
        Resp_Valid       = (r_state == RESP);
        Mem_Address      = (r_state != IDLE) ? {r_addr[31:2], 2'b00} : 32'd0;
        Mem_Write_Enable = ((r_state == STORE_W) || (r_state == RMW_WR)) && !Reset;
        Mem_Write_Data   = 32'd0;
        if (r_state == STORE_W)
            Mem_Write_Data = r_data;
        else if (r_state == RMW_WR)
            Mem_Write_Data = w_merge_data;
    end

    assign Resp_Read_Data    = r_rdata;
    assign Resp_Misaligned   = r_mis;
    assign Resp_Out_Of_Range = r_oor;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= C_RESET_STATE;
            r_write  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_data   <= 32'd0;
            r_merge  <= 32'd0;
            r_rdata  <= 32'd0;
            r_mis    <= 1'b0;
            r_oor    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write  <= Req_Write;
                r_funct3 <= Req_Funct3;
                r_addr   <= Req_Address;
                r_data   <= Req_Write_Data;
                r_rdata  <= 32'd0;
                r_mis    <= w_fault.misaligned;
                r_oor    <= w_fault.out_of_range;
            end
            if (r_state == LOAD)
                r_rdata <= w_load_data;
            if (r_state == RMW_RD)
                r_merge <= Mem_Read_Data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  tb_load_store_unit : directed + random requests against a RAM/ISA model
//  Revision: 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int MEM_WORDS = 128;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Write;
    logic [2:0]  Req_Funct3;
    logic [31:0] Req_Address;
    logic [31:0] Req_Write_Data;
    logic        Resp_Valid;
    logic        Resp_Ready;
    logic [31:0] Resp_Read_Data;
    logic        Resp_Misaligned;
    logic        Resp_Out_Of_Range;
    logic [31:0] Mem_Address;
    logic [31:0] Mem_Write_Data;
    logic        Mem_Write_Enable;
    logic [31:0] Mem_Read_Data;

    load_store_unit #(.MEM_WORDS(MEM_WORDS), .RESET_STATE(0)) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .Req_Valid         (Req_Valid),
        .Req_Ready         (Req_Ready),
        .Req_Write         (Req_Write),
        .Req_Funct3        (Req_Funct3),
        .Req_Address       (Req_Address),
        .Req_Write_Data    (Req_Write_Data),
        .Resp_Valid        (Resp_Valid),
        .Resp_Ready        (Resp_Ready),
        .Resp_Read_Data    (Resp_Read_Data),
        .Resp_Misaligned   (Resp_Misaligned),
        .Resp_Out_Of_Range (Resp_Out_Of_Range),
        .Mem_Address       (Mem_Address),
        .Mem_Write_Data    (Mem_Write_Data),
        .Mem_Write_Enable  (Mem_Write_Enable),
        .Mem_Read_Data     (Mem_Read_Data)
    );

    always #5 Clk = ~Clk;

    logic [31:0] ram   [MEM_WORDS];
    logic [31:0] model [MEM_WORDS];
    logic        preload = 1'b0;
    int          wr_total = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    assign Mem_Read_Data = (Mem_Address[31:9] == 23'd0) ? ram[Mem_Address[8:2]] : 32'h0BAD_0BAD;

    always @(posedge Clk) begin
        if (preload) begin
            for (int i = 0; i < MEM_WORDS; i++) ram[i] <= model[i];
        end else if (Mem_Write_Enable) begin
            ram[Mem_Address[8:2]] <= Mem_Write_Data;
            wr_total <= wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  {31'd0, Req_Ready}, 32'd1);
        check({tag, "_resp_valid"}, {31'd0, Resp_Valid}, 32'd0);
        check({tag, "_rdata"},      Resp_Read_Data, 32'd0);
        check({tag, "_flags"},      {30'd0, Resp_Misaligned, Resp_Out_Of_Range}, 32'd0);
        check({tag, "_we"},         {31'd0, Mem_Write_Enable}, 32'd0);
        check({tag, "_maddr"},      Mem_Address, 32'd0);
        check({tag, "_mwdata"},     Mem_Write_Data, 32'd0);
    endtask

    // Reference: ISA-level semantics over a word array.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int hold);
        logic        legal, mis, oor;
        int          idx, sh, exp_lat, exp_wr, lat, wr_before;
        logic [31:0] exp_rd, word, v, mask, held;
        idx   = int'(a >> 2);
        sh    = 8 * int'(a & 32'd3);
        legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = !legal || ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0))
                       || (f3 == 3'd2 && (a % 4 != 0));
        oor   = (a >> 2) >= MEM_WORDS;
        exp_rd = 32'd0;
        exp_wr = 0;
        if (mis || oor)      exp_lat = 1;
        else if (!w || f3 == 3'd2) exp_lat = 2;
        else                 exp_lat = 3;
        if (!mis && !oor) begin
            word = model[idx];
            if (!w) begin
                v = word >> sh;
                case (f3)
                    3'd0: begin exp_rd = v & 32'hFF;   if (exp_rd >= 32'h80)   exp_rd = exp_rd + 32'hFFFF_FF00; end
                    3'd4: exp_rd = v & 32'hFF;
                    3'd1: begin exp_rd = v & 32'hFFFF; if (exp_rd >= 32'h8000) exp_rd = exp_rd + 32'hFFFF_0000; end
                    3'd5: exp_rd = v & 32'hFFFF;
                    default: exp_rd = word;
                endcase
            end else begin
                exp_wr = 1;
                if (f3 == 3'd2)
                    model[idx] = d;
                else if (f3 == 3'd0) begin
                    mask = 32'hFF << sh;
                    model[idx] = (word & ~mask) | ((d & 32'hFF) << sh);
                end else begin
                    sh   = 8 * int'(a & 32'd2);
                    mask = 32'hFFFF << sh;
                    model[idx] = (word & ~mask) | ((d & 32'hFFFF) << sh);
                end
            end
        end

        check("req_ready_before", {31'd0, Req_Ready}, 32'd1);
        wr_before      = wr_total;
        Req_Valid      = 1'b1;
        Req_Write      = w;
        Req_Funct3     = f3;
        Req_Address    = a;
        Req_Write_Data = d;
        @(posedge Clk); #1;
        Req_Valid = 1'b0;
        lat = 1;
        while (!Resp_Valid && lat < 16) begin
            @(posedge Clk); #1;
            lat++;
        end
        check("latency",    lat, exp_lat);
        check("rdata",      Resp_Read_Data, exp_rd);
        check("misaligned", {31'd0, Resp_Misaligned}, {31'd0, mis});
        check("oor",        {31'd0, Resp_Out_Of_Range}, {31'd0, oor});
        check("ready_in_resp", {31'd0, Req_Ready}, 32'd0);
        held = Resp_Read_Data;
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk); #1;
            check("hold_valid", {31'd0, Resp_Valid}, 32'd1);
            check("hold_data",  Resp_Read_Data, held);
            check("hold_ready", {31'd0, Req_Ready}, 32'd0);
        end
        Resp_Ready = 1'b1;
        @(posedge Clk); #1;
        Resp_Ready = 1'b0;
        check("post_valid", {31'd0, Resp_Valid}, 32'd0);
        check("post_ready", {31'd0, Req_Ready}, 32'd1);
        check("writes",     wr_total - wr_before, exp_wr);
        if (idx < MEM_WORDS)
            check("ram_word", ram[idx], model[idx]);
    endtask

    initial begin
        int          wr_before;
        logic [31:0] saved;
        logic [2:0]  f3;
        logic        w;
        Reset = 1'b1;
        Req_Valid = 1'b0; Req_Write = 1'b0; Req_Funct3 = 3'd0;
        Req_Address = 32'd0; Req_Write_Data = 32'd0; Resp_Ready = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) model[i] = $urandom;
        model[1] = 32'h8899_AABB;
        #1 preload = 1'b1;
        @(posedge Clk); #1 preload = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        Reset = 1'b0;
        @(posedge Clk); #1;

        do_req(1'b0, 3'd0, 32'h0000_0005, 32'd0, 0);          // LB
        do_req(1'b0, 3'd4, 32'h0000_0005, 32'd0, 0);          // LBU
        do_req(1'b1, 3'd1, 32'h0000_0006, 32'h0000_1234, 0);  // SH
        check("sh_ram1", ram[1], 32'h1234_AABB);
        do_req(1'b0, 3'd5, 32'h0000_0006, 32'd0, 0);          // LHU
        do_req(1'b1, 3'd2, 32'h0000_0008, 32'hDEAD_BEEF, 0);  // SW
        check("sw_ram2", ram[2], 32'hDEAD_BEEF);
        do_req(1'b0, 3'd2, 32'h0000_0008, 32'd0, 0);          // LW
        do_req(1'b0, 3'd2, 32'h0000_0002, 32'd0, 0);          // misaligned LW
        do_req(1'b1, 3'd0, 32'h0000_0200, 32'h0000_00AA, 0);  // out-of-range SB
        do_req(1'b0, 3'd1, 32'h0000_0006, 32'd0, 5);          // held response

        // Reset while the SB write strobe would be active.
        saved = ram[3];
        wr_before = wr_total;
        Req_Valid = 1'b1; Req_Write = 1'b1; Req_Funct3 = 3'd0;
        Req_Address = 32'h0000_000D; Req_Write_Data = 32'h0000_0055;
        @(posedge Clk); #1;
        Req_Valid = 1'b0;
        @(posedge Clk); #1;
        check("rmw_wr_we", {31'd0, Mem_Write_Enable}, 32'd1);
        Reset = 1'b1;
        #1;
        check("rmw_wr_we_gated", {31'd0, Mem_Write_Enable}, 32'd0);
        @(posedge Clk); #1;
        check_reset_outputs("mid_reset");
        Reset = 1'b0;
        check("mid_reset_writes", wr_total - wr_before, 32'd0);
        check("mid_reset_ram3", ram[3], saved);
        @(posedge Clk); #1;

        for (int n = 0; n < 150; n++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                f3 = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
                if (!w && f3 == 3'd3) f3 = 3'd5;
            end else
                f3 = 3'($urandom_range(0, 7));
            do_req(w, f3, 32'($urandom_range(0, MEM_WORDS * 4 + 63)), $urandom,
                   int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage controller between the execute stage and a plain word-wide data RAM (byte address, word index = Address[31:2], write is whole-word only).
- Accepts one load/store request at a time over a valid/ready handshake.
- Checks alignment and range, then generates word-aligned RAM accesses. Sub-word stores use read-modify-write.
- Extracts and sign/zero-extends load data using the byte offset, and returns a response over a valid/ready handshake.

Parameters:
MEM_WORDS, 128, number of 32-bit words in the attached RAM; word index >= MEM_WORDS is out of range
RESET_STATE, 0, encoding of IDLE in the shared state type (not overridden in normal use)

Ports:
Clk  input  1  single clock, all state on posedge
Reset  input  1  synchronous, active-high
Req_Valid  input  1  request present
Req_Ready  output  1  unit can accept a request
Req_Write  input  1  1 = store, 0 = load
Req_Funct3  input  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
Req_Address  input  32  byte address
Req_Write_Data  input  32  store data, right-justified
Resp_Valid  output  1  response present
Resp_Ready  input  1  consumer accepts response
Resp_Read_Data  output  32  extended load data; 0 for stores and faults
Resp_Misaligned  output  1  alignment fault or illegal funct3
Resp_Out_Of_Range  output  1  word index >= MEM_WORDS
Mem_Address  output  32  word-aligned byte address to RAM (bits [1:0] = 00)
Mem_Write_Data  output  32  full word to RAM
Mem_Write_Enable  output  1  RAM word write strobe
Mem_Read_Data  input  32  RAM combinational read of Mem_Address

Behaviour:
- Reset values: state IDLE, Req_Ready 1, Resp_Valid 0, Resp_Read_Data 0, both fault flags 0, Mem_Write_Enable 0, Mem_Address 0, Mem_Write_Data 0.
- Reset mid-operation abandons the request with no response. Mem_Write_Enable is gated by !Reset, so no RAM write occurs in any cycle where Reset is high.
- FSM states: IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, RESP.
- Req_Ready = (state == IDLE). On accept (Req_Valid && Req_Ready), latch write flag, funct3, address, data, and offset = Req_Address[1:0].
- Fault check happens at accept. Faults go directly to RESP, with no RAM access.
  - Misaligned: halfword with addr[0] = 1; word with addr[1:0] != 0.
  - Illegal funct3: loads 011/110/111; stores other than 000/001/010. These also set Misaligned.
  - Out of range: addr[31:2] >= MEM_WORDS. If both faults apply, both flags are set.
- Next state from IDLE on accept:
  - load -> LOAD
  - SW -> STORE_W
  - SB/SH -> RMW_RD
- LOAD: drive Mem_Address; capture the extracted load data at the clock edge; -> RESP.
  - sel = Mem_Read_Data >> (8*offset).
  - LB: sign-extend sel[7]. LBU: zero-extend sel[7:0].
  - LH: sign-extend sel[15]. LHU: zero-extend sel[15:0].
  - LW: full word.
- STORE_W: Mem_Write_Enable = 1, Mem_Write_Data = latched data; -> RESP.
- RMW_RD: drive Mem_Address; capture Mem_Read_Data into merge register; -> RMW_WR.
- RMW_WR: Mem_Write_Enable = 1; Mem_Write_Data = merge word with lanes replaced; -> RESP.
  - SB: lane = offset gets data[7:0].
  - SH: lanes {offset[1],1} and {offset[1],0} get data[15:0].
  - Untouched lanes are bit-exact.
- RESP: Resp_Valid = 1, outputs held stable until Resp_Ready. On Resp_Valid && Resp_Ready -> IDLE.
- Latency from accept cycle N to first Resp_Valid cycle:
  - fault: N+1
  - load and SW: N+2
  - SB/SH: N+3
- No back-to-back requests: Req_Ready is 0 in RESP even when Resp_Ready is high. The next accept is possible one cycle after the response handshake.
- Mem_Address holds the latched aligned address in every non-IDLE state; Mem_Write_Enable is high in exactly one cycle per successful store.

Decomposition:
- Shared package lsu_pkg:
  - state enum
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - function for the fault check
- One natural sub-module: lsu_lane_align.
  - Combinational load extract/extend and store merge.
  - Inputs: offset, funct3, word, data.
  - Reused by the verification model.

Test Plan:
- Preload RAM[1] = 0x8899AABB. Load LB at 0x00000005 -> Resp_Valid at N+2, Resp_Read_Data 0xFFFFFFAA. LBU at the same address -> 0x000000AA.
- RAM[1] = 0x8899AABB. SH addr 0x00000006, data 0x00001234 -> one write, RAM[1] = 0x1234AABB, Resp_Valid at N+3. Then LHU at 0x00000006 -> 0x00001234.
- SW addr 0x00000008, data 0xDEADBEEF -> Mem_Write_Enable for exactly one cycle, RAM[2] = 0xDEADBEEF, response at N+2. LW at the same address -> 0xDEADBEEF.
- LW at 0x00000002 -> Resp_Misaligned = 1, response at N+1, no RAM write. SB at 0x00000200 with MEM_WORDS = 128 -> Resp_Out_Of_Range = 1, RAM unchanged.
- Hold Resp_Ready = 0 for 5 cycles after a load -> Resp_Valid and data stable, Req_Ready = 0 throughout; accept resumes one cycle after the handshake.
- Assert Reset during RMW_WR of an SB to word 3 -> no write (RAM[3] unchanged), no response, all outputs at reset values next cycle, Req_Ready = 1.
